rgb_fade_sequencer: RTL and testbench

- Sequences one RGB fade cycle: ramp up to a programmed colour, hold, ramp down to black.
- Advances only on single-cycle `tick` pulses from the upstream tick generator, so fade speed is set by that divider.
- Drives the 8-bit per-channel levels consumed by the gamma/PWM stage.
- Configuration is loaded through a valid/ready handshake that is accepted only while idle.

---
 rtl/rgb_fade_sequencer.sv | 125 ++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_fade_sequencer.sv
// rtl/rgb_fade_sequencer.sv - tick-paced RGB fade: ramp up to target, hold, ramp down to black
// Levels step by one per tick and saturate at target (up) or zero (down).
module rgb_fade_sequencer #(
    parameter int CW         = 8,
    parameter int HW         = 8,
    parameter int HOLD_TICKS = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          start,
    input  logic          stop,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_r,
    input  logic [CW-1:0] cfg_g,
    input  logic [CW-1:0] cfg_b,
    input  logic [HW-1:0] cfg_hold,
    output logic [CW-1:0] red,
    output logic [CW-1:0] grn,
    output logic [CW-1:0] blu,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {S_IDLE, S_RAMP_UP, S_HOLD, S_RAMP_DOWN} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_tgt_r, r_tgt_g, r_tgt_b;
    logic [CW-1:0] r_red, r_grn, r_blu;
    logic [HW-1:0] r_hold_len, r_hold_cnt;
    logic          r_done;

    logic [CW-1:0] w_up_r, w_up_g, w_up_b;
    logic [CW-1:0] w_dn_r, w_dn_g, w_dn_b;
    logic [HW-1:0] w_hold_len;
    logic          w_up_all, w_dn_zero, w_hold_last, w_cfg_accept;

    assign w_up_r = (r_red < r_tgt_r) ? r_red + CW'(1) : r_red;
    assign w_up_g = (r_grn < r_tgt_g) ? r_grn + CW'(1) : r_grn;
    assign w_up_b = (r_blu < r_tgt_b) ? r_blu + CW'(1) : r_blu;
    assign w_dn_r = (r_red != '0) ? r_red - CW'(1) : r_red;
    assign w_dn_g = (r_grn != '0) ? r_grn - CW'(1) : r_grn;
    assign w_dn_b = (r_blu != '0) ? r_blu - CW'(1) : r_blu;

    assign w_up_all     = (w_up_r == r_tgt_r) && (w_up_g == r_tgt_g) && (w_up_b == r_tgt_b);
    assign w_dn_zero    = (w_dn_r == '0) && (w_dn_g == '0) && (w_dn_b == '0);
    // A stored hold length of zero behaves as one tick.
    assign w_hold_len   = (r_hold_len == '0) ? HW'(1) : r_hold_len;
    assign w_hold_last  = (r_hold_cnt == w_hold_len - HW'(1));
    assign w_cfg_accept = cfg_valid && cfg_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (start && !stop)             w_next = S_RAMP_UP;
            S_RAMP_UP:   if (stop)                       w_next = S_RAMP_DOWN;
                         else if (tick && w_up_all)      w_next = S_HOLD;
            S_HOLD:      if (stop)                       w_next = S_RAMP_DOWN;
                         else if (tick && w_hold_last)   w_next = S_RAMP_DOWN;
            S_RAMP_DOWN: if (tick && w_dn_zero)          w_next = S_IDLE;
            default:                                     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
    end

    // A stop in RAMP_UP/HOLD wins over a coincident tick: levels and hold count freeze for that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tgt_r    <= '0;
            r_tgt_g    <= '0;
            r_tgt_b    <= '0;
            r_hold_len <= HW'(HOLD_TICKS);
            r_hold_cnt <= '0;
            r_red      <= '0;
            r_grn      <= '0;
            r_blu      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == S_RAMP_DOWN) && tick && w_dn_zero;
            if (w_cfg_accept) begin
                r_tgt_r    <= cfg_r;
                r_tgt_g    <= cfg_g;
                r_tgt_b    <= cfg_b;
                r_hold_len <= cfg_hold;
            end
            case (r_state)
                S_RAMP_UP: begin
                    if (tick && !stop) begin
                        r_red <= w_up_r;
                        r_grn <= w_up_g;
                        r_blu <= w_up_b;
                        if (w_up_all) r_hold_cnt <= '0;
                    end
                end
                S_HOLD: begin
                    if (tick && !stop && !w_hold_last) r_hold_cnt <= r_hold_cnt + HW'(1);
                end
                S_RAMP_DOWN: begin
                    if (tick) begin
                        r_red <= w_dn_r;
                        r_grn <= w_dn_g;
                        r_blu <= w_dn_b;
                    end
                end
                default: ;
            endcase
        end
    end

    assign red  = r_red;
    assign grn  = r_grn;
    assign blu  = r_blu;
    assign done = r_done;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb/tb_rgb_fade_sequencer.sv - self-checking bench for rgb_fade_sequencer
// Expected levels come from a closed-form per-tick fade profile.
module tb_rgb_fade_sequencer;

    localparam int CW = 8;
    localparam int HW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0, start = 1'b0, stop = 1'b0, cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [CW-1:0] cfg_r = '0, cfg_g = '0, cfg_b = '0;
    logic [HW-1:0] cfg_hold = '0;
    logic [CW-1:0] red, grn, blu;
    logic          busy, done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    rgb_fade_sequencer #(.CW(CW), .HW(HW), .HOLD_TICKS(16)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_r(cfg_r), .cfg_g(cfg_g), .cfg_b(cfg_b), .cfg_hold(cfg_hold),
        .red(red), .grn(grn), .blu(blu), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Level after the n-th tick of a fade: up-ramp of u ticks, hold of h ticks, down-ramp.
    function automatic int exp_level(input int n, input int t, input int u, input int h);
        if (n <= u) return (n < t) ? n : t;
        if (n <= u + h) return t;
        return (t > n - u - h) ? t - (n - u - h) : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once(input int gap);
        repeat (gap) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic load_cfg(input int r, input int g, input int b, input int h, input bit with_start);
        cfg_r = CW'(r); cfg_g = CW'(g); cfg_b = CW'(b); cfg_hold = HW'(h);
        cfg_valid = 1'b1;
        start = with_start;
        step();
        cfg_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        rst = 1'b0;
        step();
        checks++; if (red !== 8'd0)      begin errors++; $display("FAIL reset_red: got %0d want 0", red); end
        checks++; if (grn !== 8'd0)      begin errors++; $display("FAIL reset_grn: got %0d want 0", grn); end
        checks++; if (blu !== 8'd0)      begin errors++; $display("FAIL reset_blu: got %0d want 0", blu); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_cnt;
        load_cfg(3, 1, 0, 2, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %b want 1", busy); end
        for (int n = 1; n <= 8; n++) begin
            tick_once(3);
            checks++; if (red !== CW'(exp_level(n, 3, 3, 2))) begin errors++; $display("FAIL basic_red n=%0d: got %0d want %0d", n, red, exp_level(n, 3, 3, 2)); end
            checks++; if (grn !== CW'(exp_level(n, 1, 3, 2))) begin errors++; $display("FAIL basic_grn n=%0d: got %0d want %0d", n, grn, exp_level(n, 1, 3, 2)); end
            checks++; if (blu !== 8'd0) begin errors++; $display("FAIL basic_blu n=%0d: got %0d want 0", n, blu); end
            checks++; if (busy !== (n < 8)) begin errors++; $display("FAIL basic_busy n=%0d: got %b want %b", n, busy, n < 8); end
            checks++; if (done !== (n == 8)) begin errors++; $display("FAIL basic_done n=%0d: got %b want %b", n, done, n == 8); end
        end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", done); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_cfg_reject();
        int d0;
        d0 = done_cnt;
        load_cfg(5, 0, 0, 1, 1'b1);
        tick_once(1);
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reject_ready: got %b want 0", cfg_ready); end
        cfg_r = 8'd200; cfg_hold = 8'd9; cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
        for (int n = 2; n <= 11; n++) begin
            tick_once(1);
            checks++; if (red !== CW'(exp_level(n, 5, 5, 1))) begin errors++; $display("FAIL reject_red n=%0d: got %0d want %0d", n, red, exp_level(n, 5, 5, 1)); end
            checks++; if (done !== (n == 11)) begin errors++; $display("FAIL reject_done n=%0d: got %b want %b", n, done, n == 11); end
        end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reject_ready_idle: got %b want 1", cfg_ready); end
        load_cfg(200, 0, 0, 1, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        tick = 1'b1; repeat (6) step(); tick = 1'b0;
        checks++; if (red !== 8'd6) begin errors++; $display("FAIL reject_new_target: got %0d want 6", red); end
        stop = 1'b1; step(); stop = 1'b0;
        tick = 1'b1; repeat (6) step(); tick = 1'b0;
        checks++; if (red !== 8'd0) begin errors++; $display("FAIL reject_new_down: got %0d want 0", red); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL reject_new_done: got %b want 1", done); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL reject_done_count: got %0d want 1", done_cnt - d0); end
        step();
    endtask

    task automatic test_stop();
        int d0;
        d0 = done_cnt;
        load_cfg(3, 0, 0, 4, 1'b1);
        repeat (3) tick_once(0);
        tick_once(1);
        stop = 1'b1; step(); stop = 1'b0;
        checks++; if (red !== 8'd3) begin errors++; $display("FAIL stop_hold_keep: got %0d want 3", red); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stop_hold_busy: got %b want 1", busy); end
        for (int j = 1; j <= 3; j++) begin
            tick_once($urandom_range(2, 0));
            checks++; if (red !== CW'(3 - j)) begin errors++; $display("FAIL stop_hold_down j=%0d: got %0d want %0d", j, red, 3 - j); end
            checks++; if (done !== (j == 3)) begin errors++; $display("FAIL stop_hold_done j=%0d: got %b want %b", j, done, j == 3); end
        end
        step();
        load_cfg(3, 0, 0, 4, 1'b1);
        repeat (2) tick_once(1);
        checks++; if (red !== 8'd2) begin errors++; $display("FAIL stop_up_pre: got %0d want 2", red); end
        stop = 1'b1; tick = 1'b1; step(); stop = 1'b0; tick = 1'b0;
        checks++; if (red !== 8'd2) begin errors++; $display("FAIL stop_up_keep: got %0d want 2", red); end
        tick_once(1);
        checks++; if (red !== 8'd1) begin errors++; $display("FAIL stop_up_down1: got %0d want 1", red); end
        tick_once(1);
        checks++; if (red !== 8'd0) begin errors++; $display("FAIL stop_up_down0: got %0d want 0", red); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stop_up_done: got %b want 1", done); end
        step();
        checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL stop_done_count: got %0d want 2", done_cnt - d0); end
    endtask

    task automatic test_degenerate();
        int steps;
        load_cfg(1, 0, 0, 0, 1'b1);
        for (int n = 1; n <= 3; n++) begin
            tick_once(1);
            checks++; if (red !== CW'(exp_level(n, 1, 1, 1))) begin errors++; $display("FAIL hold0_red n=%0d: got %0d want %0d", n, red, exp_level(n, 1, 1, 1)); end
            checks++; if (done !== (n == 3)) begin errors++; $display("FAIL hold0_done n=%0d: got %b want %b", n, done, n == 3); end
        end
        step();
        load_cfg(0, 0, 0, 3, 1'b1);
        for (int n = 1; n <= 5; n++) begin
            tick_once(2);
            checks++; if ({red, grn, blu} !== 24'd0) begin errors++; $display("FAIL zero_levels n=%0d: got %h want 0", n, {red, grn, blu}); end
            checks++; if (busy !== (n < 5)) begin errors++; $display("FAIL zero_busy n=%0d: got %b want %b", n, busy, n < 5); end
            checks++; if (done !== (n == 5)) begin errors++; $display("FAIL zero_done n=%0d: got %b want %b", n, done, n == 5); end
        end
        step();
        load_cfg(255, 0, 0, 1, 1'b1);
        tick = 1'b1;
        for (int n = 1; n <= 255; n++) begin
            step();
            checks++; if (red !== CW'(n)) begin errors++; $display("FAIL max_up n=%0d: got %0d want %0d", n, red, n); end
        end
        step();
        checks++; if (red !== 8'd255) begin errors++; $display("FAIL max_hold_nowrap: got %0d want 255", red); end
        step();
        checks++; if (red !== 8'd254) begin errors++; $display("FAIL max_down_first: got %0d want 254", red); end
        steps = 0;
        while (done !== 1'b1 && steps < 400) begin
            step();
            steps++;
        end
        tick = 1'b0;
        checks++; if (steps !== 254) begin errors++; $display("FAIL max_down_len: got %0d want 254", steps); end
        checks++; if (red !== 8'd0) begin errors++; $display("FAIL max_down_end: got %0d want 0", red); end
        step();
    endtask

    task automatic test_start_conflicts();
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL startstop_idle: got %b want 0", busy); end
        load_cfg(2, 0, 0, 3, 1'b1);
        for (int n = 1; n <= 7; n++) begin
            tick_once(1);
            if (n == 3) begin
                start = 1'b1; step(); start = 1'b0;
            end
            checks++; if (red !== CW'(exp_level(n, 2, 2, 3))) begin errors++; $display("FAIL start_hold_red n=%0d: got %0d want %0d", n, red, exp_level(n, 2, 2, 3)); end
            checks++; if (done !== (n == 7)) begin errors++; $display("FAIL start_hold_done n=%0d: got %b want %b", n, done, n == 7); end
        end
        step();
        load_cfg(5, 0, 0, 1, 1'b1);
        tick = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            step();
            checks++; if (red !== CW'(exp_level(n, 5, 5, 1))) begin errors++; $display("FAIL start_cfg_red n=%0d: got %0d want %0d", n, red, exp_level(n, 5, 5, 1)); end
            checks++; if (done !== (n == 11)) begin errors++; $display("FAIL start_cfg_done n=%0d: got %b want %b", n, done, n == 11); end
        end
        tick = 1'b0;
        step();
    endtask

    task automatic test_random();
        int tr, tg, tb, h, u, hh, total, d0, mx;
        for (int it = 0; it < 6; it++) begin
            d0 = done_cnt;
            tr = $urandom_range(12, 0); tg = $urandom_range(12, 0); tb = $urandom_range(12, 0);
            h  = $urandom_range(4, 0);
            mx = (tr > tg) ? tr : tg;
            mx = (mx > tb) ? mx : tb;
            u  = (mx > 0) ? mx : 1;
            hh = (h > 0) ? h : 1;
            total = 2 * u + hh;
            if ($urandom_range(1, 0) == 1) load_cfg(tr, tg, tb, h, 1'b1);
            else begin
                load_cfg(tr, tg, tb, h, 1'b0);
                start = 1'b1; step(); start = 1'b0;
            end
            for (int n = 1; n <= total; n++) begin
                if ($urandom_range(3, 0) == 0) begin
                    cfg_r = CW'($urandom); cfg_g = CW'($urandom); cfg_b = CW'($urandom); cfg_hold = HW'($urandom);
                    cfg_valid = 1'b1;
                    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rand_ready it=%0d n=%0d: got %b want 0", it, n, cfg_ready); end
                end
                tick_once($urandom_range(2, 0));
                cfg_valid = 1'b0;
                checks++; if (red !== CW'(exp_level(n, tr, u, hh))) begin errors++; $display("FAIL rand_red it=%0d n=%0d: got %0d want %0d", it, n, red, exp_level(n, tr, u, hh)); end
                checks++; if (grn !== CW'(exp_level(n, tg, u, hh))) begin errors++; $display("FAIL rand_grn it=%0d n=%0d: got %0d want %0d", it, n, grn, exp_level(n, tg, u, hh)); end
                checks++; if (blu !== CW'(exp_level(n, tb, u, hh))) begin errors++; $display("FAIL rand_blu it=%0d n=%0d: got %0d want %0d", it, n, blu, exp_level(n, tb, u, hh)); end
                checks++; if (busy !== (n < total)) begin errors++; $display("FAIL rand_busy it=%0d n=%0d: got %b want %b", it, n, busy, n < total); end
            end
            step();
            checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rand_done_count it=%0d: got %0d want 1", it, done_cnt - d0); end
        end
    endtask

    task automatic test_async_reset();
        int d0;
        load_cfg(4, 4, 4, 1, 1'b1);
        tick = 1'b1; repeat (6) step(); tick = 1'b0;
        checks++; if (red !== 8'd3) begin errors++; $display("FAIL arst_pre: got %0d want 3", red); end
        d0 = done_cnt;
        #3 rst = 1'b1;
        #1;
        checks++; if ({red, grn, blu} !== 24'd0) begin errors++; $display("FAIL arst_levels: got %h want 0", {red, grn, blu}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b want 0", done); end
        repeat (2) step();
        #2 rst = 1'b0;
        step();
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL arst_no_done: got %0d want %0d", done_cnt, d0); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b want 1", cfg_ready); end
        start = 1'b1; step(); start = 1'b0;
        tick = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            step();
            checks++; if (red !== 8'd0) begin errors++; $display("FAIL arst_hold_red n=%0d: got %0d want 0", n, red); end
            checks++; if (done !== (n == 18)) begin errors++; $display("FAIL arst_hold_done n=%0d: got %b want %b", n, done, n == 18); end
        end
        tick = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cfg_reject();
        test_stop();
        test_degenerate();
        test_start_conflicts();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
